// File: rtl/mul8_shift_add.sv
// ============================================================================
// Module  : mul8_shift_add (with its FullAdder_8bit ripple-carry adder)
// Purpose : Sequential 8x8 unsigned shift-and-add multiplier, 8 iterations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module FullAdder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

module mul8_shift_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  logic [7:0]  add_b;
  logic [7:0]  add_sum;
  logic        add_cout;

  assign add_b = q_q[0] ? m_q : 8'h00;

  FullAdder_8bit u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The adder carry is shifted straight into A[7] on the same edge, so it
  // never needs to outlive the cycle in its own flop.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = 8'h00;
          cnt_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = {add_cout, add_sum[7:1]};
        q_d   = {add_sum[0], q_q[7:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          product_d = {add_cout, add_sum[7:1], add_sum[0], q_q[7:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= 8'h00;
      q_q       <= 8'h00;
      m_q       <= 8'h00;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

`default_nettype wire
